// File: rtl/nodf_status_pkg.sv
// Shared types and default widths for the ap_ctrl_hs status tracker.
package nodf_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACTIVE   = 2'b01,
    ST_STALL    = 2'b10,
    ST_FINISHED = 2'b11
  } state_e;

  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned DEF_OUT_W = 4;
  localparam int unsigned DEF_LAT_W = 32;

endpackage

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter with a freeze input; holds at all-ones instead of wrapping.
module nodf_sat_counter
  import nodf_status_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         freeze_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !freeze_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/nodf_module_status.sv
// Status tracker for one ap_ctrl_hs block: state, event counters, outstanding and latency.
module nodf_module_status
  import nodf_status_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned LAT_W = DEF_LAT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] start_count,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] ready_count,
  output logic [CNT_W-1:0] busy_cycles,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [OUT_W-1:0] outstanding,
  output logic [LAT_W-1:0] last_latency,
  output logic [LAT_W-1:0] max_latency,
  output logic             proto_err,
  output logic             finished
);

  logic accept, complete, stall_ev, busy_inc;
  assign accept   = ap_start & ap_ready;
  assign complete = ap_done & ap_continue;
  assign stall_ev = ap_done & ~ap_continue;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               perr_q, perr_d, fin_q, fin_d, armed_q, armed_d, lat_valid;
  logic [LAT_W-1:0]   timer_q, timer_d, last_q, last_d, max_q, max_d, lat_sample;

  assign fin_d = fin_q | finish;

  always_comb begin
    out_d  = out_q;
    perr_d = perr_q;
    if (!fin_q) begin
      if (accept && !complete) begin
        if (out_q == '1) perr_d = 1'b1;
        else             out_d  = out_q + OUT_W'(1);
      end else if (complete && !accept) begin
        if (out_q == '0) perr_d = 1'b1;
        else             out_d  = out_q - OUT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (fin_q || finish)                           state_d = ST_FINISHED;
    else if (stall_ev)                             state_d = ST_STALL;
    else if (ap_start || (out_d != '0) || ap_done) state_d = ST_ACTIVE;
  end

  assign busy_inc = (state_d == ST_ACTIVE) || (state_d == ST_STALL);

  // Timer holds (cycles since accept); only the transaction starting from empty is timed.
  always_comb begin
    armed_d    = armed_q;
    timer_d    = timer_q;
    last_d     = last_q;
    max_d      = max_q;
    lat_valid  = 1'b0;
    lat_sample = '0;
    if (!fin_q) begin
      if (armed_q && (timer_q != '1)) timer_d = timer_q + LAT_W'(1);
      if (complete && armed_q) begin
        lat_valid  = 1'b1;
        lat_sample = timer_q;
        armed_d    = 1'b0;
      end else if (complete && accept && (out_q == '0)) begin
        lat_valid  = 1'b1;
      end else if (accept && (out_q == '0)) begin
        armed_d = 1'b1;
        timer_d = LAT_W'(1);
      end
      if (lat_valid) begin
        last_d = lat_sample;
        if (lat_sample > max_q) max_d = lat_sample;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      perr_q  <= 1'b0;
      fin_q   <= 1'b0;
      armed_q <= 1'b0;
      timer_q <= '0;
      last_q  <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      perr_q  <= perr_d;
      fin_q   <= fin_d;
      armed_q <= armed_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      max_q   <= max_d;
    end
  end

  nodf_sat_counter #(.W(CNT_W)) u_start (.clk_i(clock), .rst_i(reset), .inc_i(accept),
                                         .freeze_i(fin_q), .cnt_o(start_count));
  nodf_sat_counter #(.W(CNT_W)) u_done  (.clk_i(clock), .rst_i(reset), .inc_i(complete),
                                         .freeze_i(fin_q), .cnt_o(done_count));
  nodf_sat_counter #(.W(CNT_W)) u_ready (.clk_i(clock), .rst_i(reset), .inc_i(ap_ready),
                                         .freeze_i(fin_q), .cnt_o(ready_count));
  nodf_sat_counter #(.W(CNT_W)) u_busy  (.clk_i(clock), .rst_i(reset), .inc_i(busy_inc),
                                         .freeze_i(fin_q), .cnt_o(busy_cycles));
  nodf_sat_counter #(.W(CNT_W)) u_stall (.clk_i(clock), .rst_i(reset), .inc_i(stall_ev),
                                         .freeze_i(fin_q), .cnt_o(stall_cycles));

  assign state        = state_q;
  assign outstanding  = out_q;
  assign last_latency = last_q;
  assign max_latency  = max_q;
  assign proto_err    = perr_q;
  assign finished     = fin_q;

endmodule

// File: tb/tb_nodf_module_status.sv
// Directed bench for nodf_module_status with a cycle-level reference model and literal checkpoints.
module tb_nodf_module_status;

  localparam int unsigned CW = 8;
  localparam int unsigned OW = 2;
  localparam int unsigned LW = 4;
  localparam longint CMAX = 255;
  localparam longint OMAX = 3;
  localparam longint LMAX = 15;

  logic clock = 1'b0;
  logic reset, ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [1:0]    state;
  logic [CW-1:0] start_count, done_count, ready_count, busy_cycles, stall_cycles;
  logic [OW-1:0] outstanding;
  logic [LW-1:0] last_latency, max_latency;
  logic          proto_err, finished;

  nodf_module_status #(.CNT_W(CW), .OUT_W(OW), .LAT_W(LW)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .state(state), .start_count(start_count), .done_count(done_count),
    .ready_count(ready_count), .busy_cycles(busy_cycles), .stall_cycles(stall_cycles),
    .outstanding(outstanding), .last_latency(last_latency), .max_latency(max_latency),
    .proto_err(proto_err), .finished(finished)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  longint m_start, m_done, m_ready, m_busy, m_stall, m_out, m_last, m_max, m_cyc, m_acc_cyc;
  int     m_state;
  bit     m_perr, m_fin, m_timing;

  task automatic chk(input string nm, input logic [63:0] act, input longint exp);
    n_tests++;
    if (act !== 64'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_start = 0; m_done = 0; m_ready = 0; m_busy = 0; m_stall = 0;
    m_out = 0; m_last = 0; m_max = 0; m_cyc = 0; m_acc_cyc = 0;
    m_state = 0; m_perr = 0; m_fin = 0; m_timing = 0;
  endtask

  task automatic model_step(input bit s, input bit r, input bit d, input bit c, input bit f);
    bit acc, cmp, stl;
    longint n, lat;
    acc = s & r; cmp = d & c; stl = d & ~c;
    m_cyc++;
    if (m_fin) begin
      m_state = 3;
      return;
    end
    m_start = sat(m_start + acc, CMAX);
    m_done  = sat(m_done + cmp, CMAX);
    m_ready = sat(m_ready + r, CMAX);
    m_stall = sat(m_stall + stl, CMAX);
    n = m_out + acc - cmp;
    if (n < 0)    begin n = 0;    m_perr = 1; end
    if (n > OMAX) begin n = OMAX; m_perr = 1; end
    if (cmp && m_timing) begin
      lat = sat(m_cyc - m_acc_cyc, LMAX);
      m_last = lat;
      if (lat > m_max) m_max = lat;
      m_timing = 0;
    end else if (cmp && acc && m_out == 0) begin
      m_last = 0;
    end else if (acc && m_out == 0) begin
      m_timing = 1;
      m_acc_cyc = m_cyc;
    end
    m_out = n;
    if (f)                      m_state = 3;
    else if (stl)               m_state = 2;
    else if (s || n > 0 || d)   m_state = 1;
    else                        m_state = 0;
    if (m_state == 1 || m_state == 2) m_busy = sat(m_busy + 1, CMAX);
    m_fin = f;
  endtask

  always @(posedge clock) begin
    if (reset) model_reset();
    else model_step(ap_start, ap_ready, ap_done, ap_continue, finish);
    #1;
    chk("state", state, m_state);
    chk("start_count", start_count, m_start);
    chk("done_count", done_count, m_done);
    chk("ready_count", ready_count, m_ready);
    chk("busy_cycles", busy_cycles, m_busy);
    chk("stall_cycles", stall_cycles, m_stall);
    chk("outstanding", outstanding, m_out);
    chk("last_latency", last_latency, m_last);
    chk("max_latency", max_latency, m_max);
    chk("proto_err", proto_err, m_perr);
    chk("finished", finished, m_fin);
  end

  task automatic step(input bit s, input bit r, input bit d, input bit c, input bit f);
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
    repeat (3) @(negedge clock);
    chk("rst_state", state, 0);
    chk("rst_start", start_count, 0);
    chk("rst_busy", busy_cycles, 0);
    chk("rst_finished", finished, 0);
    reset = 1'b0;
    repeat (10) step(0, 0, 0, 0, 0);
    chk("idle_state", state, 0);

    // single transaction, done five cycles after accept
    step(1, 1, 0, 1, 0);
    repeat (4) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("t1_start", start_count, 1);
    chk("t1_done", done_count, 1);
    chk("t1_ready", ready_count, 1);
    chk("t1_last", last_latency, 5);
    chk("t1_max", max_latency, 5);
    chk("t1_out", outstanding, 0);
    chk("t1_state", state, 0);
    chk("t1_busy", busy_cycles, 6);

    // back-pressure: three stalled done cycles
    step(1, 1, 0, 1, 0);
    repeat (2) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    chk("bp_state_stall", state, 2);
    repeat (2) step(0, 0, 1, 0, 0);
    chk("bp_done_held", done_count, 1);
    chk("bp_stall", stall_cycles, 3);
    step(0, 0, 1, 1, 0);
    chk("bp_done", done_count, 2);
    chk("bp_last", last_latency, 6);
    step(0, 0, 0, 1, 0);
    chk("bp_busy", busy_cycles, 13);
    chk("bp_state_idle", state, 0);

    // ready-only traffic
    repeat (7) begin
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    chk("ro_ready", ready_count, 9);
    chk("ro_start", start_count, 2);
    chk("ro_state", state, 0);

    // protocol errors: done with nothing outstanding, then overflow
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("pe_err", proto_err, 1);
    chk("pe_out0", outstanding, 0);
    repeat (4) step(1, 1, 0, 1, 0);
    chk("pe_out_sat", outstanding, 3);
    chk("pe_err_sticky", proto_err, 1);
    repeat (3) step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("pe_last", last_latency, 4);
    chk("pe_max", max_latency, 6);
    chk("pe_drain", outstanding, 0);

    // latency timer saturation
    step(1, 1, 0, 1, 0);
    repeat (20) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("ls_last", last_latency, 15);
    chk("ls_max", max_latency, 15);

    // counter saturation
    repeat (250) step(0, 1, 0, 0, 0);
    chk("cs_ready", ready_count, 255);

    // finish freeze
    step(1, 1, 0, 1, 1);
    chk("fz_start", start_count, 8);
    chk("fz_state", state, 3);
    chk("fz_finished", finished, 1);
    chk("fz_out", outstanding, 1);
    step(0, 0, 1, 1, 1);
    step(1, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("fz_start_held", start_count, 8);
    chk("fz_out_held", outstanding, 1);
    chk("fz_state_held", state, 3);

    // asynchronous reset clears immediately
    reset = 1'b1;
    #1;
    chk("ar_finished", finished, 0);
    chk("ar_start", start_count, 0);
    chk("ar_ready", ready_count, 0);
    chk("ar_state", state, 0);
    chk("ar_max", max_latency, 0);
    @(negedge clock);
    reset = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("post_state", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
